// File: rtl/vs_tx_fsm.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// A one-word holding register lets a new frame follow the last stop bit with no idle gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line at 1, baud divider held in reset, waiting for a word
// S_START | start bit (0) on TXD
// S_DATA  | data bit d[cnt_q] on TXD
// S_PAR   | even parity bit on TXD
// S_STOP1 | first stop bit (1) on TXD
// S_STOP2 | second stop bit (1) on TXD
module vs_tx_fsm #(
  parameter bit PAR_EN = 1'b1,
  parameter bit STOP2  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_CE,
  input  logic       TX_DATA_EN,
  input  logic [7:0] TX_DATA,
  output logic       TX_RDY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TXCT_R,
  output logic       TXD
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
  } state_t;

  state_t     state, state_d;
  logic [7:0] hold_q, sr_q, sr_d;
  logic       hold_full;
  logic [2:0] cnt_q, cnt_d;
  logic       txd_q, txd_d;
  logic       txct_q, txct_d;
  logic       done_q, done_d;
  logic       load;
  logic       eof;

  always_comb begin
    state_d = state;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    txct_d  = txct_q;
    done_d  = 1'b0;
    load    = 1'b0;
    eof     = 1'b0;
    case (state)
      S_IDLE: begin
        txd_d  = 1'b1;
        txct_d = 1'b1;
        if (hold_full) begin
          load    = 1'b1;
          sr_d    = hold_q;
          txd_d   = 1'b0;
          txct_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (TX_CE) begin
          txd_d   = sr_q[0];
          cnt_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (TX_CE) begin
          if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
            txd_d = sr_q[cnt_q + 3'd1];
          end else if (PAR_EN) begin
            txd_d   = ^sr_q;
            state_d = S_PAR;
          end else begin
            txd_d   = 1'b1;
            state_d = S_STOP1;
          end
        end
      end
      S_PAR: begin
        if (TX_CE) begin
          txd_d   = 1'b1;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (TX_CE) begin
          if (STOP2) state_d = S_STOP2;
          else       eof     = 1'b1;
        end
      end
      S_STOP2: begin
        if (TX_CE) eof = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A waiting word starts immediately so the divider never restarts between frames.
    if (eof) begin
      done_d = 1'b1;
      if (hold_full) begin
        load    = 1'b1;
        sr_d    = hold_q;
        txd_d   = 1'b0;
        txct_d  = 1'b0;
        state_d = S_START;
      end else begin
        txd_d   = 1'b1;
        txct_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      hold_q    <= 8'h00;
      hold_full <= 1'b0;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
      txd_q     <= 1'b1;
      txct_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state  <= state_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      txd_q  <= txd_d;
      txct_q <= txct_d;
      done_q <= done_d;
      if (load) begin
        hold_full <= 1'b0;
      end else if (TX_DATA_EN && !hold_full) begin
        hold_q    <= TX_DATA;
        hold_full <= 1'b1;
      end
    end
  end

  assign TX_RDY  = ~hold_full;
  assign TX_BUSY = (state != S_IDLE);
  assign TX_DONE = done_q;
  assign TXCT_R  = txct_q;
  assign TXD     = txd_q;

endmodule
